// File: rtl/debounce_multi.sv
// N-channel debouncer: per-channel settle counter and STABLE/SETTLE FSM, clean level plus rise/fall pulses.
// Optional 2-flop input synchroniser enabled by defining DEBOUNCE_SYNC_EN.
module debounce_multi #(
    parameter int CH         = 4,
    parameter int STABLE_CNT = 16,
    parameter bit INIT_LEVEL = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic [CH-1:0] sig_in,
    output logic [CH-1:0] db_sig,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic [CH-1:0] busy,
    output logic          any_change
);

    localparam int CNT_W = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    typedef enum logic {
        STABLE = 1'b0,
        SETTLE = 1'b1
    } state_t;

    logic [CH-1:0] s;

`ifdef DEBOUNCE_SYNC_EN
    logic [CH-1:0] sync_a;
    logic [CH-1:0] sync_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= {CH{INIT_LEVEL}};
            sync_b <= {CH{INIT_LEVEL}};
        end else begin
            sync_a <= sig_in;
            sync_b <= sync_a;
        end
    end

    assign s = sync_b;
`else
    assign s = sig_in;
`endif

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             level;
        logic             rise_q;
        logic             fall_q;
        logic             busy_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state  <= STABLE;
                cnt    <= '0;
                level  <= INIT_LEVEL;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                case (state)
                    STABLE: begin
                        // Leaving STABLE does not wait for a tick.
                        if (s[i] != level) begin
                            state  <= SETTLE;
                            cnt    <= '0;
                            busy_q <= 1'b1;
                        end
                    end
                    SETTLE: begin
                        if (s[i] == level) begin
                            state  <= STABLE;
                            cnt    <= '0;
                            busy_q <= 1'b0;
                        end else if (tick) begin
                            if (cnt == CNT_LAST) begin
                                level  <= s[i];
                                rise_q <= s[i];
                                fall_q <= ~s[i];
                                state  <= STABLE;
                                cnt    <= '0;
                                busy_q <= 1'b0;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state  <= STABLE;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end

        assign db_sig[i] = level;
        assign rise[i]   = rise_q;
        assign fall[i]   = fall_q;
        assign busy[i]   = busy_q;
    end

    assign any_change = |(rise | fall);

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi (CH=4, STABLE_CNT=4): table vectors plus hand sequences, expected-queue scoreboard.
module tb_debounce_multi;

    localparam int CH  = 4;
    localparam int STB = 4;

    logic          clk;
    logic          reset;
    logic          tick;
    logic [CH-1:0] sig_in;
    logic [CH-1:0] db_sig;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] busy;
    logic          any_change;

    debounce_multi #(
        .CH(CH),
        .STABLE_CNT(STB),
        .INIT_LEVEL(1'b0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tick(tick),
        .sig_in(sig_in),
        .db_sig(db_sig),
        .rise(rise),
        .fall(fall),
        .busy(busy),
        .any_change(any_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sig;
        logic       tck;
        logic [3:0] db;
        logic [3:0] rs;
        logic [3:0] fl;
        logic [3:0] bs;
    } vec_t;

    vec_t        tbl[0:31];
    int          n_vec  = 0;
    int          checks = 0;
    int          errors = 0;
    logic [16:0] exp_q[$];

    task automatic add(input logic [3:0] sg, input logic tk, input logic [3:0] d,
                       input logic [3:0] r, input logic [3:0] f, input logic [3:0] b);
        tbl[n_vec] = '{sg, tk, d, r, f, b};
        n_vec++;
    endtask

    task automatic expect_out(input logic [3:0] d, input logic [3:0] r,
                              input logic [3:0] f, input logic [3:0] b);
        exp_q.push_back({d, r, f, b, |(r | f)});
    endtask

    task automatic compare_out(input string name);
        logic [16:0] exp_v;
        logic [16:0] act_v;
        if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s: scoreboard empty at t=%0t", name, $time);
        end else begin
            exp_v = exp_q.pop_front();
            act_v = {db_sig, rise, fall, busy, any_change};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL %s #%0d t=%0t: got db/rise/fall/busy/any=%b_%b_%b_%b_%b required %b_%b_%b_%b_%b",
                         name, checks, $time, act_v[16:13], act_v[12:9], act_v[8:5], act_v[4:1], act_v[0],
                         exp_v[16:13], exp_v[12:9], exp_v[8:5], exp_v[4:1], exp_v[0]);
            end
        end
    endtask

    task automatic step(input string name, input logic [3:0] sg, input logic tk,
                        input logic [3:0] d, input logic [3:0] r,
                        input logic [3:0] f, input logic [3:0] b);
        sig_in = sg;
        tick   = tk;
        expect_out(d, r, f, b);
        @(posedge clk);
        #1;
        compare_out(name);
    endtask

    // Hold new_sig with tick=1; after lat cycles the masked channels settle for STB edges, then pulse once.
    task automatic settle_seq(input string name, input logic [3:0] new_sig, input logic [3:0] old_db,
                              input logic [3:0] new_db, input logic [3:0] mask, input int lat);
        for (int k = 0; k < lat + STB + 2; k++) begin
            step(name, new_sig, 1'b1,
                 (k >= lat + STB) ? new_db : old_db,
                 (k == lat + STB) ? (mask & new_db) : 4'b0000,
                 (k == lat + STB) ? (mask & ~new_db) : 4'b0000,
                 (k >= lat && k < lat + STB) ? mask : 4'b0000);
        end
    endtask

    initial begin
        reset  = 1'b0;
        tick   = 1'b1;
        sig_in = 4'b0000;
        #12;
        expect_out(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        compare_out("reset_state");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 20; k++) step("idle_zero", 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

`ifdef DEBOUNCE_SYNC_EN
        settle_seq("sync_rise0", 4'b0001, 4'b0000, 4'b0001, 4'b0001, 2);
        settle_seq("sync_rise1", 4'b0011, 4'b0001, 4'b0011, 4'b0010, 2);
        settle_seq("sync_fall01", 4'b0000, 4'b0011, 4'b0000, 4'b0011, 2);
`else
        // Channel 0 accepted rise, then channel 1 bounces and never settles.
        for (int k = 0; k < 4; k++) add(4'b0001, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(4'b0001, 1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        add(4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0011, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0010);
        add(4'b0011, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0010);
        add(4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(4'b0011, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0010);
        add(4'b0011, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0010);
        for (int k = 0; k < 4; k++) add(4'b0001, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        for (int v = 0; v < n_vec; v++)
            step("table", tbl[v].sig, tbl[v].tck, tbl[v].db, tbl[v].rs, tbl[v].fl, tbl[v].bs);

        // Channel 2 with tick every third clock: four ticks needed after entering SETTLE.
        for (int k = 0; k < 13; k++)
            step("slow_tick", 4'b0101, (k % 3 == 2),
                 (k >= 11) ? 4'b0101 : 4'b0001,
                 (k == 11) ? 4'b0100 : 4'b0000,
                 4'b0000,
                 (k < 11) ? 4'b0100 : 4'b0000);

        // Channel 3 aborted mid-settle by an async reset.
        for (int k = 0; k < 3; k++) step("pre_abort", 4'b1101, 1'b1, 4'b0101, 4'b0000, 4'b0000, 4'b1000);
        reset  = 1'b0;
        sig_in = 4'b0000;
        #1;
        expect_out(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        compare_out("async_abort");
        @(posedge clk);
        #1;
        expect_out(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        compare_out("abort_held");
        reset = 1'b1;
        for (int k = 0; k < 3; k++) step("post_abort", 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        settle_seq("restart3", 4'b1000, 4'b0000, 4'b1000, 4'b1000, 0);
        settle_seq("rise01", 4'b1011, 4'b1000, 4'b1011, 4'b0011, 0);
        settle_seq("fall01", 4'b1000, 4'b1011, 4'b1000, 4'b0011, 0);
`endif

        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
